// File: rtl/ibus_cksyn_pkg.sv
// rtl/ibus_cksyn_pkg.sv - shared state encoding, default width and ratio legality check
// for the ibus clock-sync toggle/strobe generator.
package ibus_cksyn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } cksyn_state_e;

  localparam int DEF_CNT_W = 4;

  // A ratio is usable when it is non-zero and fits in cnt_w bits.
  function automatic bit ratio_legal(input int ratio, input int cnt_w);
    return (ratio >= 1) && (ratio <= ((1 << cnt_w) - 1));
  endfunction

endpackage

// File: rtl/ibus_cksyn_cnt.sv
// rtl/ibus_cksyn_cnt.sv - interval counter running 0..ratio-1 with wrap detect.
// Held at zero while disabled; clr restarts the interval against a newly applied ratio.
module ibus_cksyn_cnt
  import ibus_cksyn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_ext,
  input  logic             rst_a,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] ratio,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // ratio is never zero, so ratio-1 cannot underflow.
  assign wrap = en && (cnt == (ratio - ONE));

  always_ff @(posedge clk_ext or posedge rst_a) begin
    if (rst_a) begin
      cnt <= '0;
    end else if (!en || clr || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/ibus_cksyn_gen.sv
// rtl/ibus_cksyn_gen.sv - programmable toggle/strobe generator with req/ack ratio change.
// New ratios take effect only on an interval boundary (or while idle), so toggle never runts.
module ibus_cksyn_gen
  import ibus_cksyn_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DEF_RATIO = 1
) (
  input  logic             clk_ext,
  input  logic             rst_a,
  input  logic             en,
  input  logic             ratio_req,
  input  logic [CNT_W-1:0] ratio_in,
  output logic             ratio_ack,
  output logic [CNT_W-1:0] ratio_cur,
  output logic             toggle,
  output logic             strobe
);

  // An illegal DEF_RATIO falls back to the legacy half-rate ratio of 1.
  localparam int               DEF_R_INT = ratio_legal(DEF_RATIO, CNT_W) ? DEF_RATIO : 1;
  localparam logic [CNT_W-1:0] DEF_R     = CNT_W'(DEF_R_INT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  cksyn_state_e     state_q;
  cksyn_state_e     state_d;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] pend_d;
  logic [CNT_W-1:0] apply_val;
  logic [CNT_W-1:0] ratio_clamped;
  logic             ack_seen;
  logic             req_new;
  logic             apply;
  logic             wrap;

  assign ratio_clamped = (ratio_in == '0) ? ONE : ratio_in;
  // A request still held after its own ack must not be taken as a new one.
  assign req_new       = ratio_req && !ack_seen;

  ibus_cksyn_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_ext (clk_ext),
    .rst_a   (rst_a),
    .en      (en),
    .clr     (apply),
    .ratio   (ratio_cur),
    .wrap    (wrap)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_r;
    apply     = 1'b0;
    apply_val = ratio_clamped;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
        if (req_new) apply = 1'b1;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (req_new) begin
          if (wrap) begin
            apply = 1'b1;
          end else begin
            pend_d  = ratio_clamped;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        apply_val = pend_r;
        if (!en) begin
          apply   = 1'b1;
          state_d = IDLE;
        end else if (wrap) begin
          apply   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ext or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= IDLE;
      pend_r    <= '0;
      ack_seen  <= 1'b0;
      ratio_cur <= DEF_R;
      ratio_ack <= 1'b0;
      toggle    <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_r    <= pend_d;
      ratio_ack <= apply;
      strobe    <= wrap;
      if (apply) ratio_cur <= apply_val;
      if (wrap) toggle <= ~toggle;
      if (apply) begin
        ack_seen <= 1'b1;
      end else if (!ratio_req) begin
        ack_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibus_cksyn_gen.sv
// tb/tb_ibus_cksyn_gen.sv - directed self-checking bench for ibus_cksyn_gen.
module tb_ibus_cksyn_gen;

  logic       clk_ext;
  logic       rst_a;
  logic       en;
  logic       ratio_req;
  logic [3:0] ratio_in;
  logic       ratio_ack;
  logic [3:0] ratio_cur;
  logic       toggle;
  logic       strobe;

  int total = 0;
  int bad   = 0;

  ibus_cksyn_gen #(
    .CNT_W     (4),
    .DEF_RATIO (1)
  ) dut (
    .clk_ext   (clk_ext),
    .rst_a     (rst_a),
    .en        (en),
    .ratio_req (ratio_req),
    .ratio_in  (ratio_in),
    .ratio_ack (ratio_ack),
    .ratio_cur (ratio_cur),
    .toggle    (toggle),
    .strobe    (strobe)
  );

  initial begin
    clk_ext = 1'b0;
    forever #5 clk_ext = ~clk_ext;
  end

  task automatic tick();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp4(input string tag, input int tg, input int sb, input int ak, input int cur);
    chk({tag, ".toggle"}, int'(toggle), tg);
    chk({tag, ".strobe"}, int'(strobe), sb);
    chk({tag, ".ack"}, int'(ratio_ack), ak);
    chk({tag, ".ratio_cur"}, int'(ratio_cur), cur);
  endtask

  initial begin
    rst_a     = 1'b1;
    en        = 1'b0;
    ratio_req = 1'b0;
    ratio_in  = 4'd0;
    #1;
    exp4("reset", 0, 0, 0, 1);
    tick();
    tick();
    rst_a = 1'b0;

    // ratio 1: flip every cycle
    en = 1'b1;
    tick(); exp4("r1.c1", 1, 1, 0, 1);
    tick(); exp4("r1.c2", 0, 1, 0, 1);
    tick(); exp4("r1.c3", 1, 1, 0, 1);
    tick(); exp4("r1.c4", 0, 1, 0, 1);

    // ratio 3 set from IDLE, then run
    en = 1'b0;
    tick(); exp4("idle", 0, 0, 0, 1);
    ratio_req = 1'b1; ratio_in = 4'd3;
    tick(); exp4("set3.ack", 0, 0, 1, 3);
    tick(); exp4("set3.ackend", 0, 0, 0, 3);
    ratio_req = 1'b0; en = 1'b1;
    tick(); exp4("r3.a", 0, 0, 0, 3);
    tick(); exp4("r3.b", 0, 0, 0, 3);
    tick(); exp4("r3.c", 1, 1, 0, 3);
    tick(); exp4("r3.d", 1, 0, 0, 3);
    tick(); exp4("r3.e", 1, 0, 0, 3);
    tick(); exp4("r3.f", 0, 1, 0, 3);

    // request 5 at cnt=1 -> PEND, applied at wrap
    tick(); exp4("p5.g", 0, 0, 0, 3);
    ratio_req = 1'b1; ratio_in = 4'd5;
    tick(); exp4("p5.h", 0, 0, 0, 3);
    ratio_in = 4'd7;
    tick(); exp4("p5.wrap", 1, 1, 1, 5);
    tick(); exp4("p5.j", 1, 0, 0, 5);
    ratio_req = 1'b0;
    tick(); exp4("p5.k", 1, 0, 0, 5);
    tick(); exp4("p5.l", 1, 0, 0, 5);
    tick(); exp4("p5.m", 1, 0, 0, 5);
    tick(); exp4("p5.n", 0, 1, 0, 5);

    // ratio 0 clamps to 1
    ratio_req = 1'b1; ratio_in = 4'd0;
    tick(); exp4("z.o", 0, 0, 0, 5);
    tick(); exp4("z.p", 0, 0, 0, 5);
    tick(); exp4("z.q", 0, 0, 0, 5);
    tick(); exp4("z.r", 0, 0, 0, 5);
    tick(); exp4("z.wrap", 1, 1, 1, 1);
    tick(); exp4("z.t", 0, 1, 0, 1);
    ratio_req = 1'b0;
    tick(); exp4("z.u", 1, 1, 0, 1);
    tick(); exp4("z.v", 0, 1, 0, 1);

    // wrap and apply in the same cycle, then PEND with en dropped
    ratio_req = 1'b1; ratio_in = 4'd4;
    tick(); exp4("wa.w", 1, 1, 1, 4);
    tick(); exp4("wa.x", 1, 0, 0, 4);
    ratio_req = 1'b0;
    tick(); exp4("wa.y", 1, 0, 0, 4);
    ratio_req = 1'b1; ratio_in = 4'd2;
    tick(); exp4("pd.z", 1, 0, 0, 4);
    en = 1'b0;
    tick(); exp4("pd.ack", 1, 0, 1, 2);
    tick(); exp4("pd.hold1", 1, 0, 0, 2);
    tick(); exp4("pd.hold2", 1, 0, 0, 2);
    tick(); exp4("pd.hold3", 1, 0, 0, 2);
    ratio_req = 1'b0;
    tick(); exp4("pd.ee", 1, 0, 0, 2);

    // reset asserted between edges while PEND
    en = 1'b1;
    tick(); exp4("rs.f1", 1, 0, 0, 2);
    tick(); exp4("rs.f2", 0, 1, 0, 2);
    tick(); exp4("rs.f3", 0, 0, 0, 2);
    tick(); exp4("rs.f4", 1, 1, 0, 2);
    ratio_req = 1'b1; ratio_in = 4'd6;
    tick(); exp4("rs.f5", 1, 0, 0, 2);
    #2;
    rst_a = 1'b1;
    #1;
    exp4("rs.async", 0, 0, 0, 1);
    en = 1'b0; ratio_req = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    tick(); exp4("rs.post1", 0, 0, 0, 1);
    tick(); exp4("rs.post2", 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
